// File: rtl/arcino_prefetch_ctrl.sv
// arcino_prefetch_ctrl
// Instruction fetch sequencer that sits between the IF stage, the instruction
// memory port and the fetch FIFO. It keeps at most one memory request
// outstanding. Each returned word is tagged with its fetch address and pushed
// into the FIFO. A branch clears the FIFO, redirects fetching to the target
// and discards any response that is still in flight.
module arcino_prefetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        busy_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    input  logic        fifo_ready_i
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        WAIT_GNT     = 2'b01,
        WAIT_RVALID  = 2'b10,
        WAIT_ABORTED = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] fetch_addr_r;
    logic [31:0] fetch_addr_nxt_s;
    logic [31:0] rsp_addr_r;
    logic [31:0] rsp_addr_nxt_s;

    logic [31:0] target_s;
    logic [31:0] seq_addr_s;
    logic [31:0] base_addr_s;
    logic [31:0] ea_s;
    logic        issue_ok_s;
    logic        req_s;
    logic        push_s;

    // Bit 0 of the branch target is never used: instructions are at least halfword aligned.
    logic        branch_addr_unused_s;
    assign branch_addr_unused_s = branch_addr_i[0];

    // Effective fetch address and the issue condition shared by every issuing state.
    always_comb begin
        target_s   = {branch_addr_i[31:1], 1'b0};
        // The sequential successor drops bit 1, so only the first word after a branch carries it.
        seq_addr_s = {rsp_addr_r[31:2] + 30'd1, 2'b00};
        if ((state_r == WAIT_RVALID) && instr_rvalid_i) begin
            base_addr_s = seq_addr_s;
        end else begin
            base_addr_s = fetch_addr_r;
        end
        if (branch_i) begin
            ea_s = target_s;
        end else begin
            ea_s = base_addr_s;
        end
        // A full FIFO blocks new issues unless the same-cycle branch clears it.
        issue_ok_s = req_i & (fifo_ready_i | branch_i);
    end

    // Next-state, next-address and raw request/push decisions.
    always_comb begin
        state_nxt_s      = state_r;
        fetch_addr_nxt_s = fetch_addr_r;
        rsp_addr_nxt_s   = rsp_addr_r;
        req_s            = 1'b0;
        push_s           = 1'b0;
        case (state_r)
            IDLE: begin
                req_s = issue_ok_s;
                if (issue_ok_s && instr_gnt_i) begin
                    rsp_addr_nxt_s = ea_s;
                    state_nxt_s    = WAIT_RVALID;
                end else if (issue_ok_s) begin
                    fetch_addr_nxt_s = ea_s;
                    state_nxt_s      = WAIT_GNT;
                end else if (branch_i) begin
                    fetch_addr_nxt_s = target_s;
                end else begin
                    fetch_addr_nxt_s = fetch_addr_r;
                end
            end
            WAIT_GNT: begin
                // Request is held until accepted; its address may still be redirected.
                req_s = 1'b1;
                if (instr_gnt_i) begin
                    rsp_addr_nxt_s = ea_s;
                    state_nxt_s    = WAIT_RVALID;
                end else if (branch_i) begin
                    fetch_addr_nxt_s = target_s;
                end else begin
                    fetch_addr_nxt_s = fetch_addr_r;
                end
            end
            WAIT_RVALID, WAIT_ABORTED: begin
                if (instr_rvalid_i) begin
                    // Aborted responses and responses coinciding with a branch are dropped.
                    push_s           = (state_r == WAIT_RVALID) & ~branch_i;
                    fetch_addr_nxt_s = ea_s;
                    req_s            = issue_ok_s;
                    if (issue_ok_s && instr_gnt_i) begin
                        rsp_addr_nxt_s = ea_s;
                        state_nxt_s    = WAIT_RVALID;
                    end else if (issue_ok_s) begin
                        state_nxt_s = WAIT_GNT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else if (branch_i) begin
                    fetch_addr_nxt_s = target_s;
                    state_nxt_s      = WAIT_ABORTED;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and address registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            fetch_addr_r <= BOOT_ADDR;
            rsp_addr_r   <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            fetch_addr_r <= fetch_addr_nxt_s;
            rsp_addr_r   <= rsp_addr_nxt_s;
        end
    end

    // Bus and FIFO outputs; control strobes are silenced while reset is held.
    always_comb begin
        instr_req_o  = req_s & ~rst_i;
        instr_addr_o = {ea_s[31:2], 2'b00};
        fifo_clear_o = branch_i & ~rst_i;
        fifo_valid_o = push_s & ~rst_i;
        fifo_addr_o  = rsp_addr_r;
        fifo_rdata_o = instr_rdata_i;
        busy_o       = (state_r != IDLE) & ~rst_i;
    end

endmodule

// File: tb/tb_arcino_prefetch_ctrl.sv
// Testbench for arcino_prefetch_ctrl: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_arcino_prefetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        busy_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_ready_i;

    int checks = 0;
    int errors = 0;

    arcino_prefetch_ctrl #(.BOOT_ADDR(BOOT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_ready_i   (fifo_ready_i)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rq, input logic br, input logic [31:0] ba,
                         input logic rdy, input logic gn, input logic rv);
        req_i          = rq;
        branch_i       = br;
        branch_addr_i  = ba;
        fifo_ready_i   = rdy;
        instr_gnt_i    = gn;
        instr_rvalid_i = rv;
        instr_rdata_i  = $urandom;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", instr_req_o); end
        checks++; if (fifo_clear_o !== 1'b0) begin errors++; $display("FAIL rst_clear: got %b want 0", fifo_clear_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fifo_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL rst_idle_req: got %b want 0", instr_req_o); end
        next_cycle();
    endtask

    task automatic test_sequential;
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin errors++; $display("FAIL seq_req0: got %b/%h want 1/00000080", instr_req_o, instr_addr_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL seq_nopush0: got %b want 0", fifo_valid_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h80) begin errors++; $display("FAIL seq_push0: got %b/%h want 1/00000080", fifo_valid_o, fifo_addr_o); end
        checks++; if (fifo_rdata_o !== instr_rdata_i) begin errors++; $display("FAIL seq_rdata: got %h want %h", fifo_rdata_o, instr_rdata_i); end
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h84) begin errors++; $display("FAIL seq_req1: got %b/%h want 1/00000084", instr_req_o, instr_addr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL seq_busy: got %b want 1", busy_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h84) begin errors++; $display("FAIL seq_push1: got %b/%h want 1/00000084", fifo_valid_o, fifo_addr_o); end
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h88) begin errors++; $display("FAIL seq_req2: got %b/%h want 1/00000088", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h88) begin errors++; $display("FAIL seq_push2: got %b/%h want 1/00000088", fifo_valid_o, fifo_addr_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL seq_stop: got %b want 0", instr_req_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL seq_idle: got %b want 0", busy_o); end
        next_cycle();
    endtask

    task automatic test_fifo_full;
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h84) begin errors++; $display("FAIL full_push: got %b/%h want 1/00000084", fifo_valid_o, fifo_addr_o); end
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL full_noreq0: got %b want 0", instr_req_o); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL full_noreq%0d: got %b want 0", i + 1, instr_req_o); end
            next_cycle();
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h88) begin errors++; $display("FAIL full_resume: got %b/%h want 1/00000088", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h88) begin errors++; $display("FAIL full_push88: got %b/%h want 1/00000088", fifo_valid_o, fifo_addr_o); end
        next_cycle();
    endtask

    task automatic test_branch_abort;
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b1, 1'b1, 32'h0000_1002, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0) begin errors++; $display("FAIL abort_noreq: got %b want 0", instr_req_o); end
        checks++; if (fifo_clear_o !== 1'b1) begin errors++; $display("FAIL abort_clear: got %b want 1", fifo_clear_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (fifo_clear_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL abort_wait: got clear=%b busy=%b want 0/1", fifo_clear_o, busy_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL abort_drop: got %b want 0", fifo_valid_o); end
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h1000) begin errors++; $display("FAIL abort_req: got %b/%h want 1/00001000", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h1002) begin errors++; $display("FAIL abort_push: got %b/%h want 1/00001002", fifo_valid_o, fifo_addr_o); end
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h1004) begin errors++; $display("FAIL abort_next: got %b/%h want 1/00001004", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h1004) begin errors++; $display("FAIL abort_push2: got %b/%h want 1/00001004", fifo_valid_o, fifo_addr_o); end
        next_cycle();
    endtask

    task automatic test_delayed_grant;
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin errors++; $display("FAIL dly_req0: got %b/%h want 1/00000080", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin errors++; $display("FAIL dly_hold: got %b/%h want 1/00000080", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin errors++; $display("FAIL dly_redirect: got %b/%h want 1/00000200", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h200) begin errors++; $display("FAIL dly_gnt: got %b/%h want 1/00000200", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h200) begin errors++; $display("FAIL dly_rsp_addr: got %b/%h want 1/00000200", fifo_valid_o, fifo_addr_o); end
        next_cycle();
    endtask

    task automatic test_wrap;
        do_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got %b/%h want 1/fffffffc", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_push: got %b/%h want 1/fffffffc", fifo_valid_o, fifo_addr_o); end
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_req1: got %b/%h want 1/00000000", instr_req_o, instr_addr_o); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checks++; if (fifo_valid_o !== 1'b1 || fifo_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_push0: got %b/%h want 1/00000000", fifo_valid_o, fifo_addr_o); end
        next_cycle();
    endtask

    task automatic test_reset_midway;
        do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst: got req=%b busy=%b want 0/0", instr_req_o, busy_o); end
        next_cycle();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mid_idle: got req=%b busy=%b want 0/0", instr_req_o, busy_o); end
        next_cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (instr_req_o !== 1'b1 || instr_addr_o !== BOOT) begin errors++; $display("FAIL mid_boot: got %b/%h want 1/%h", instr_req_o, instr_addr_o, BOOT); end
        next_cycle();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle();
    endtask

    // Transaction-level model: the next word to fetch, a pending (unaccepted)
    // request, and at most one accepted word awaiting data, possibly cancelled.
    task automatic test_random;
        logic [31:0] m_next;
        logic [31:0] m_out_addr;
        logic [31:0] nxt;
        bit          m_pend;
        bit          m_out;
        bit          m_drop;
        bit          r_rst, r_req, r_br, r_rdy, r_gnt, r_rv;
        logic [31:0] r_ba;
        bit          e_req;
        bit          e_push;
        bit          e_busy;
        do_reset();
        m_next = BOOT; m_pend = 0; m_out = 0; m_drop = 0; m_out_addr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_req = ($urandom_range(0, 3) != 0);
            r_br  = ($urandom_range(0, 7) == 0);
            r_ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_gnt = ($urandom_range(0, 1) != 0);
            r_rv  = m_out && ($urandom_range(0, 1) != 0);
            rst_i = r_rst;
            drive(r_req, r_br, r_ba, r_rdy, r_gnt, r_rv);
            @(negedge clk);
            if (r_rst) begin
                checks++; if ({instr_req_o, fifo_valid_o, fifo_clear_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL rnd_rst c%0d: got req/val/clr/busy=%b%b%b%b want 0000", cyc, instr_req_o, fifo_valid_o, fifo_clear_o, busy_o); end
                m_next = BOOT; m_pend = 0; m_out = 0; m_drop = 0;
            end else begin
                e_busy = m_pend || m_out;
                e_push = r_rv && !m_drop && !r_br;
                nxt = m_next;
                if (r_rv && !m_drop) nxt = (m_out_addr & ~32'd3) + 32'd4;
                if (r_br) nxt = r_ba & ~32'd1;
                e_req = m_pend || ((!m_out || r_rv) && r_req && (r_rdy || r_br));
                checks++; if (instr_req_o !== e_req) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", cyc, instr_req_o, e_req); end
                if (e_req) begin
                    checks++; if (instr_addr_o !== (nxt & ~32'd3)) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, instr_addr_o, nxt & ~32'd3); end
                end
                checks++; if (fifo_valid_o !== e_push) begin errors++; $display("FAIL rnd_push c%0d: got %b want %b", cyc, fifo_valid_o, e_push); end
                if (e_push) begin
                    checks++; if (fifo_addr_o !== m_out_addr) begin errors++; $display("FAIL rnd_faddr c%0d: got %h want %h", cyc, fifo_addr_o, m_out_addr); end
                    checks++; if (fifo_rdata_o !== instr_rdata_i) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, fifo_rdata_o, instr_rdata_i); end
                end
                checks++; if (fifo_clear_o !== r_br) begin errors++; $display("FAIL rnd_clear c%0d: got %b want %b", cyc, fifo_clear_o, r_br); end
                checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy_o, e_busy); end
                if (r_br && m_out && !r_rv) m_drop = 1;
                if (r_rv) begin m_out = 0; m_drop = 0; end
                m_next = nxt;
                if (e_req) begin
                    if (r_gnt) begin m_out = 1; m_drop = 0; m_out_addr = nxt; m_pend = 0; end
                    else m_pend = 1;
                end
            end
            next_cycle();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle();
        test_reset();
        test_sequential();
        test_fifo_full();
        test_branch_abort();
        test_delayed_grant();
        test_wrap();
        test_reset_midway();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
